// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer: opcodes, FSM states and the
// packed command word that travels through the command FIFO.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;

    localparam int CMD_W = 19;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    function automatic cmd_t pack_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        cmd_t c;
        c.op = op;
        c.a  = a;
        c.b  = b;
        return c;
    endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Bundle of the command, ALU start/done and response handshakes around the issuer.
// slave = issuer view, master = host/ALU environment view.
interface alu_cmd_issuer_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;

    logic        alu_start;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_done;
    logic [15:0] alu_result;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_op;
    logic        rsp_err;

    logic        busy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b,
        output cmd_ready,
        output alu_start, alu_op, alu_a, alu_b,
        input  alu_done, alu_result,
        output rsp_valid, rsp_result, rsp_op, rsp_err,
        input  rsp_ready,
        output busy
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b,
        input  cmd_ready,
        input  alu_start, alu_op, alu_a, alu_b,
        output alu_done, alu_result,
        input  rsp_valid, rsp_result, rsp_op, rsp_err,
        output rsp_ready,
        input  busy
    );

endinterface

// File: rtl/alu_cmd_issuer_fifo.sv
// Small synchronous command FIFO; the head entry is visible combinationally so
// the issuer can load it in the same cycle it pops.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = CMD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues buffered ALU commands one at a time over a start/done interface and
// returns each result (or a timeout error) on a valid/ready response port.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    alu_cmd_issuer_if.slave   bus
);

    localparam int CW = $clog2(TIMEOUT);

    state_e          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic            done_q_reg;
    logic            alu_start_reg;
    logic [2:0]      alu_op_reg;
    logic [7:0]      alu_a_reg;
    logic [7:0]      alu_b_reg;
    logic            rsp_valid_reg;
    logic [15:0]     rsp_result_reg;
    logic [2:0]      rsp_op_reg;
    logic            rsp_err_reg;

    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_pop;
    cmd_t            fifo_din;
    cmd_t            fifo_head;
    logic            done_rise;

    assign fifo_push = bus.cmd_valid && !fifo_full;
    assign fifo_pop  = (state_reg == ST_IDLE) && !fifo_empty;
    assign fifo_din  = pack_cmd(bus.cmd_op, bus.cmd_a, bus.cmd_b);
    assign done_rise = bus.alu_done && !done_q_reg;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            done_q_reg     <= 1'b0;
            alu_start_reg  <= 1'b0;
            alu_op_reg     <= '0;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_result_reg <= '0;
            rsp_op_reg     <= '0;
            rsp_err_reg    <= 1'b0;
        end else begin
            // Edge detector runs in every state so a level left high from an
            // earlier op never counts as a fresh completion.
            done_q_reg <= bus.alu_done;
            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        alu_op_reg    <= fifo_head.op;
                        alu_a_reg     <= fifo_head.a;
                        alu_b_reg     <= fifo_head.b;
                        alu_start_reg <= 1'b1;
                        state_reg     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    alu_start_reg <= 1'b0;
                    cnt_reg       <= '0;
                    state_reg     <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (done_rise) begin
                        rsp_result_reg <= bus.alu_result;
                        rsp_op_reg     <= alu_op_reg;
                        rsp_err_reg    <= 1'b0;
                        rsp_valid_reg  <= 1'b1;
                        state_reg      <= ST_RESP;
                    end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                        rsp_result_reg <= '0;
                        rsp_op_reg     <= alu_op_reg;
                        rsp_err_reg    <= 1'b1;
                        rsp_valid_reg  <= 1'b1;
                        state_reg      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = !fifo_full;
    assign bus.alu_start  = alu_start_reg;
    assign bus.alu_op     = alu_op_reg;
    assign bus.alu_a      = alu_a_reg;
    assign bus.alu_b      = alu_b_reg;
    assign bus.rsp_valid  = rsp_valid_reg;
    assign bus.rsp_result = rsp_result_reg;
    assign bus.rsp_op     = rsp_op_reg;
    assign bus.rsp_err    = rsp_err_reg;
    assign bus.busy       = (state_reg != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: behavioural alu_top with programmable done delay and
// a queue-based reference of the expected responses.
module tb_alu_cmd_issuer;

    localparam int TIMEOUT_P = 64;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } tcmd_t;

    logic clk;
    logic reset;
    alu_cmd_issuer_if bus();

    alu_cmd_issuer #(.DEPTH(4), .TIMEOUT(TIMEOUT_P)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic of alu_top: signed 8-bit operands, 16-bit result.
    function automatic logic [15:0] golden(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int sa;
        int sb;
        int r;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'd0: r = sa + sb;
            3'd1: r = sa - sb;
            3'd2: r = sa * sb;
            3'd3: r = (sb == 0) ? 0 : sa / sb;
            3'd4: r = sa & sb;
            3'd5: r = sa | sb;
            3'd6: r = sa ^ sb;
            default: r = 0;
        endcase
        return r[15:0];
    endfunction

    // Behavioural alu_top: latches operands on start, pulses done alu_delay cycles later.
    int          alu_delay   = 2;
    bit          alu_never   = 1'b0;
    int          pend_cnt    = 0;
    logic        done_pulse  = 1'b0;
    logic        done_manual = 1'b0;
    logic [15:0] model_res   = 16'h0;

    assign bus.alu_done   = done_pulse | done_manual;
    assign bus.alu_result = model_res;

    always @(posedge clk) begin
        done_pulse <= 1'b0;
        if (bus.alu_start === 1'b1) begin
            model_res <= golden(bus.alu_op, bus.alu_a, bus.alu_b);
            pend_cnt  <= alu_never ? 0 : alu_delay;
        end else if (pend_cnt > 0) begin
            pend_cnt <= pend_cnt - 1;
            if (pend_cnt == 1) done_pulse <= 1'b1;
        end
    end

    task automatic push_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, output bit ok);
        ok = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        for (int i = 0; i < 200; i++) begin
            if (bus.cmd_ready === 1'b1) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic pop_rsp(output logic [15:0] res, output logic [2:0] op, output logic err,
                           output int waited, output bit ok);
        ok = 1'b0;
        waited = 0;
        res = '0;
        op = '0;
        err = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (bus.rsp_valid === 1'b1) begin
                res = bus.rsp_result;
                op  = bus.rsp_op;
                err = bus.rsp_err;
                ok  = 1'b1;
                @(negedge clk);
                break;
            end
            waited++;
            @(negedge clk);
        end
        bus.rsp_ready = 1'b0;
        $display("rsp op=%0d result=%h err=%0d waited=%0d", op, res, err, waited);
    endtask

    task automatic test_reset;
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b want=1", bus.cmd_ready); end
        total++; if (bus.alu_start !== 1'b0) begin bad++; $display("FAIL reset_alu_start got=%b want=0", bus.alu_start); end
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if ({bus.rsp_result, bus.rsp_op, bus.rsp_err} !== 20'h0) begin bad++;
            $display("FAIL reset_rsp_fields got=%h/%h/%b want=0", bus.rsp_result, bus.rsp_op, bus.rsp_err); end
        total++; if ({bus.alu_op, bus.alu_a, bus.alu_b} !== 19'h0) begin bad++;
            $display("FAIL reset_alu_fields got=%h/%h/%h want=0", bus.alu_op, bus.alu_a, bus.alu_b); end
    endtask

    task automatic test_add;
        bit ok; logic s0; logic s1; int starts; int k;
        logic [15:0] res; logic [2:0] op; logic err; int w;
        alu_delay = 3;
        push_cmd(3'b000, 8'd25, 8'd17, ok);
        total++; if (!ok) begin bad++; $display("FAIL add_accept got=0 want=1"); end
        s0 = bus.alu_start;
        @(negedge clk);
        s1 = bus.alu_start;
        total++; if ({s0, s1} !== 2'b01) begin bad++; $display("FAIL add_start_latency got=%b want=01", {s0, s1}); end
        starts = 1;
        k = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            k++;
            if (bus.alu_start === 1'b1) starts++;
            if (bus.rsp_valid === 1'b1) break;
        end
        total++; if (starts != 1) begin bad++; $display("FAIL add_start_count got=%0d want=1", starts); end
        total++; if (k != 5) begin bad++; $display("FAIL add_rsp_latency got=%0d want=5", k); end
        pop_rsp(res, op, err, w, ok);
        total++; if (!ok || res !== 16'd42 || op !== 3'b000 || err !== 1'b0) begin bad++;
            $display("FAIL add_rsp got=%h/%0d/%b want=002a/0/0", res, op, err); end
    endtask

    task automatic test_back_to_back;
        bit ok1; bit ok2; logic [15:0] res; logic [2:0] op; logic err; int w;
        alu_delay = 2;
        push_cmd(3'b010, 8'hF6, 8'd5, ok1);
        push_cmd(3'b011, 8'h9C, 8'd4, ok2);
        total++; if (!ok1 || !ok2) begin bad++; $display("FAIL b2b_accept got=%b%b want=11", ok1, ok2); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b want=1", bus.busy); end
        pop_rsp(res, op, err, w, ok1);
        total++; if (!ok1 || res !== 16'hFFCE || op !== 3'b010 || err !== 1'b0) begin bad++;
            $display("FAIL b2b_mul got=%h/%0d/%b want=ffce/2/0", res, op, err); end
        pop_rsp(res, op, err, w, ok1);
        total++; if (!ok1 || res !== 16'hFFE7 || op !== 3'b011 || err !== 1'b0) begin bad++;
            $display("FAIL b2b_div got=%h/%0d/%b want=ffe7/3/0", res, op, err); end
    endtask

    task automatic test_full;
        tcmd_t cmds[6];
        tcmd_t exp_q[$];
        tcmd_t e;
        int idx; int start_viol; int stab_viol;
        logic prev_v; logic [15:0] prev_res; logic [2:0] prev_op; logic prev_err;
        logic [15:0] res; logic [2:0] op; logic err; int w; bit ok;
        alu_delay = 1;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cmds[i].op = 3'($urandom_range(0, 6));
            cmds[i].a  = 8'($urandom);
            cmds[i].b  = 8'($urandom);
        end
        idx = 0; start_viol = 0; stab_viol = 0; prev_v = 1'b0;
        prev_res = '0; prev_op = '0; prev_err = 1'b0;
        for (int c = 0; c < 20; c++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = cmds[idx].op;
            bus.cmd_a     = cmds[idx].a;
            bus.cmd_b     = cmds[idx].b;
            if (bus.cmd_ready === 1'b1) begin
                exp_q.push_back(cmds[idx]);
                idx++;
            end
            if (bus.alu_start === 1'b1 && bus.rsp_valid === 1'b1) start_viol++;
            if (prev_v && (bus.rsp_valid !== 1'b1 || bus.rsp_result !== prev_res ||
                           bus.rsp_op !== prev_op || bus.rsp_err !== prev_err)) stab_viol++;
            prev_v = (bus.rsp_valid === 1'b1);
            prev_res = bus.rsp_result; prev_op = bus.rsp_op; prev_err = bus.rsp_err;
            @(negedge clk);
        end
        total++; if (idx != 5) begin bad++; $display("FAIL full_accepted got=%0d want=5", idx); end
        total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL full_cmd_ready got=%b want=0", bus.cmd_ready); end
        total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL full_rsp_valid got=%b want=1", bus.rsp_valid); end
        total++; if (start_viol != 0) begin bad++; $display("FAIL full_start_during_rsp got=%0d want=0", start_viol); end
        total++; if (stab_viol != 0) begin bad++; $display("FAIL full_rsp_stable got=%0d want=0", stab_viol); end
        bus.cmd_valid = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pop_rsp(res, op, err, w, ok);
            total++; if (!ok || res !== golden(e.op, e.a, e.b) || op !== e.op || err !== 1'b0) begin bad++;
                $display("FAIL full_drain got=%h/%0d/%b want=%h/%0d/0", res, op, err, golden(e.op, e.a, e.b), e.op); end
        end
        repeat (2) @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL full_idle_busy got=%b want=0", bus.busy); end
    endtask

    task automatic test_timeout;
        bit ok; int k; logic [15:0] res; logic [2:0] op; logic err; int w;
        alu_never = 1'b1;
        push_cmd(3'b001, 8'd9, 8'd3, ok);
        for (int i = 0; i < 10 && bus.alu_start !== 1'b1; i++) @(negedge clk);
        total++; if (bus.alu_start !== 1'b1) begin bad++; $display("FAIL tmo_start got=%b want=1", bus.alu_start); end
        k = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            k++;
            if (bus.rsp_valid === 1'b1) break;
        end
        total++; if (k != TIMEOUT_P + 1) begin bad++; $display("FAIL tmo_latency got=%0d want=%0d", k, TIMEOUT_P + 1); end
        pop_rsp(res, op, err, w, ok);
        total++; if (!ok || res !== 16'h0 || op !== 3'b001 || err !== 1'b1) begin bad++;
            $display("FAIL tmo_rsp got=%h/%0d/%b want=0000/1/1", res, op, err); end
        alu_never = 1'b0;
        alu_delay = 2;
        push_cmd(3'b101, 8'h30, 8'h0F, ok);
        pop_rsp(res, op, err, w, ok);
        total++; if (!ok || res !== 16'h003F || op !== 3'b101 || err !== 1'b0) begin bad++;
            $display("FAIL tmo_next got=%h/%0d/%b want=003f/5/0", res, op, err); end
    endtask

    task automatic test_stale;
        bit ok; int early; logic [15:0] res; logic [2:0] op; logic err; int w;
        alu_never = 1'b1;
        done_manual = 1'b1;
        repeat (2) @(negedge clk);
        push_cmd(3'b110, 8'hA5, 8'h3C, ok);
        early = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.rsp_valid === 1'b1) early++;
            @(negedge clk);
        end
        total++; if (early != 0) begin bad++; $display("FAIL stale_no_completion got=%0d want=0", early); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL stale_busy got=%b want=1", bus.busy); end
        done_manual = 1'b0;
        @(negedge clk);
        done_manual = 1'b1;
        @(negedge clk);
        done_manual = 1'b0;
        total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL stale_fresh_edge got=%b want=1", bus.rsp_valid); end
        pop_rsp(res, op, err, w, ok);
        total++; if (!ok || res !== golden(3'b110, 8'hA5, 8'h3C) || op !== 3'b110 || err !== 1'b0) begin bad++;
            $display("FAIL stale_rsp got=%h/%0d/%b want=%h/6/0", res, op, err, golden(3'b110, 8'hA5, 8'h3C)); end
        alu_never = 1'b0;
    endtask

    task automatic test_reset_mid;
        bit ok; int seen; logic s0; logic s1; logic [15:0] res; logic [2:0] op; logic err; int w;
        alu_delay = 20;
        push_cmd(3'b000, 8'd1, 8'd2, ok);
        for (int i = 0; i < 10 && bus.alu_start !== 1'b1; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.alu_start !== 1'b0) begin bad++;
            $display("FAIL rstmid_outputs got=v%b b%b r%b s%b want=v0 b0 r1 s0", bus.rsp_valid, bus.busy, bus.cmd_ready, bus.alu_start); end
        total++; if ({bus.alu_op, bus.alu_a, bus.alu_b, bus.rsp_result} !== 35'h0) begin bad++;
            $display("FAIL rstmid_regs got=%h/%h/%h/%h want=0", bus.alu_op, bus.alu_a, bus.alu_b, bus.rsp_result); end
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.rsp_valid === 1'b1) seen++;
            @(negedge clk);
        end
        total++; if (seen != 0) begin bad++; $display("FAIL rstmid_no_rsp got=%0d want=0", seen); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", bus.busy); end
        alu_delay = 2;
        push_cmd(3'b010, 8'd7, 8'd6, ok);
        s0 = bus.alu_start;
        @(negedge clk);
        s1 = bus.alu_start;
        total++; if ({s0, s1} !== 2'b01) begin bad++; $display("FAIL rstmid_start_latency got=%b want=01", {s0, s1}); end
        pop_rsp(res, op, err, w, ok);
        total++; if (!ok || res !== 16'd42 || op !== 3'b010 || err !== 1'b0) begin bad++;
            $display("FAIL rstmid_rsp got=%h/%0d/%b want=002a/2/0", res, op, err); end
    endtask

    task automatic test_random;
        tcmd_t exp_q[$];
        tcmd_t c;
        tcmd_t e;
        int sent; int got;
        logic hold; logic [15:0] h_res; logic [2:0] h_op; logic h_err;
        sent = 0; got = 0; hold = 1'b0; h_res = '0; h_op = '0; h_err = 1'b0;
        for (int cyc = 0; cyc < 4000 && got < 40; cyc++) begin
            alu_delay = $urandom_range(1, 6);
            c.op = 3'($urandom_range(0, 6));
            c.a  = 8'($urandom);
            c.b  = 8'($urandom);
            bus.cmd_valid = (sent < 40) && ($urandom_range(0, 2) != 0);
            bus.cmd_op = c.op; bus.cmd_a = c.a; bus.cmd_b = c.b;
            if (bus.cmd_valid && bus.cmd_ready === 1'b1) begin
                exp_q.push_back(c);
                sent++;
            end
            bus.rsp_ready = 1'($urandom_range(0, 1));
            if (hold) begin
                total++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== h_res || bus.rsp_op !== h_op || bus.rsp_err !== h_err) begin
                    bad++;
                    $display("FAIL rand_hold got=%b/%h/%0d/%b want=1/%h/%0d/%b", bus.rsp_valid, bus.rsp_result, bus.rsp_op, bus.rsp_err, h_res, h_op, h_err);
                end
            end
            if (bus.alu_start === 1'b1) begin
                total++;
                if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rand_start_during_rsp got=1 want=0"); end
            end
            if (bus.rsp_valid === 1'b1 && bus.rsp_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rand_unexpected_rsp got=%h want=none", bus.rsp_result);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.rsp_result !== golden(e.op, e.a, e.b) || bus.rsp_op !== e.op || bus.rsp_err !== 1'b0) begin
                        bad++;
                        $display("FAIL rand_rsp got=%h/%0d/%b want=%h/%0d/0", bus.rsp_result, bus.rsp_op, bus.rsp_err, golden(e.op, e.a, e.b), e.op);
                    end
                end
                $display("rand rsp #%0d op=%0d result=%h err=%0d", got, bus.rsp_op, bus.rsp_result, bus.rsp_err);
                got++;
            end
            hold = (bus.rsp_valid === 1'b1) && !bus.rsp_ready;
            h_res = bus.rsp_result; h_op = bus.rsp_op; h_err = bus.rsp_err;
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        total++; if (got != 40) begin bad++; $display("FAIL rand_count got=%0d want=40", got); end
    endtask

    initial begin
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = '0;
        bus.cmd_a = '0;
        bus.cmd_b = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset;
        test_add;
        test_back_to_back;
        test_full;
        test_timeout;
        test_stale;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
